// File: rtl/adc_scan_ctrl.sv
// Purpose: sweeps ADC channels 0..N_CH-1 on a rising go; per channel sc pulse, wait eoc, read with oe low, tag sample.
// Latency: sc high SC_CYCLES cycles starting 1 cycle after the go edge; data_valid SC_CYCLES+3 cycles after it if eoc is immediate.
// Backpressure: none downstream; the ADC paces each channel via eoc, a stalled channel is dropped after TIMEOUT WAIT cycles.
//
// Optional feature: define ADC_SCAN_CONT_EN for continuous sweeping while go is held high.
// Ports:
//   clk, reset (async, active-low)      clock and reset
//   go                                  scan request level, only its rising edge starts a sweep
//   eoc, adc_data                       ADC end-of-conversion and parallel sample
//   sc, oe, ch_sel                      ADC start-conversion, active-low output enable, mux select
//   data_out, data_ch, data_valid       captured sample, its channel, one-cycle strobe
//   busy, done, timeout_err             sweep in progress, sweep-complete strobe, sticky timeout flag
`timescale 1ns/1ps
module adc_scan_ctrl #(
    parameter int N_CH      = 4,
    parameter int DATA_W    = 8,
    parameter int SC_CYCLES = 2,
    parameter int TIMEOUT   = 16,
    localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              go,
    input  logic              eoc,
    input  logic [DATA_W-1:0] adc_data,
    output logic              sc,
    output logic              oe,
    output logic [CH_W-1:0]   ch_sel,
    output logic [DATA_W-1:0] data_out,
    output logic [CH_W-1:0]   data_ch,
    output logic              data_valid,
    output logic              busy,
    output logic              done,
    output logic              timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_READ  = 2'd3
    } state_t;

    // One counter serves both the sc pulse width and the WAIT timeout.
    localparam int CNT_MAX = (SC_CYCLES > TIMEOUT) ? SC_CYCLES : TIMEOUT;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] SC_LAST = CNT_W'(SC_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
    localparam logic [CH_W-1:0]  CH_LAST = CH_W'(N_CH - 1);
    localparam bit               TO_EN   = (TIMEOUT > 0);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             go_d;

    logic go_rise;
    logic last_ch;
    logic timeout_hit;
    logic advance;

    assign go_rise     = go & ~go_d;
    assign last_ch     = (ch_sel == CH_LAST);
    // eoc has priority over the timeout when both land on the same cycle.
    assign timeout_hit = TO_EN && (state == ST_WAIT) && !eoc && (cnt == TO_LAST);
    // Channel finished, either by a completed read or by abandoning it.
    assign advance     = (state == ST_READ) || timeout_hit;

    // Moore output decode {sc, oe, busy}, loaded together with the state so
    // the pins come straight from flops.
    function automatic logic [2:0] moore(input state_t s);
        case (s)
            ST_START: moore = 3'b111;
            ST_WAIT:  moore = 3'b011;
            ST_READ:  moore = 3'b001;
            default:  moore = 3'b010;
        endcase
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= ST_IDLE;
            {sc, oe, busy} <= 3'b010;
            ch_sel         <= '0;
            cnt            <= '0;
            go_d           <= 1'b0;
            data_out       <= '0;
            data_ch        <= '0;
            data_valid     <= 1'b0;
            done           <= 1'b0;
            timeout_err    <= 1'b0;
        end else begin
            go_d       <= go;
            data_valid <= 1'b0;
            done       <= 1'b0;

            case (state)
                ST_IDLE: begin
                    ch_sel <= '0;
                    cnt    <= '0;
                    if (go_rise) begin
                        // Error flag covers the current/last sweep only.
                        timeout_err    <= 1'b0;
                        state          <= ST_START;
                        {sc, oe, busy} <= moore(ST_START);
                    end
                end
                ST_START: begin
                    if (cnt == SC_LAST) begin
                        cnt            <= '0;
                        state          <= ST_WAIT;
                        {sc, oe, busy} <= moore(ST_WAIT);
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_WAIT: begin
                    if (eoc) begin
                        cnt            <= '0;
                        state          <= ST_READ;
                        {sc, oe, busy} <= moore(ST_READ);
                    end else if (timeout_hit) begin
                        timeout_err <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_READ: begin
                    data_out   <= adc_data;
                    data_ch    <= ch_sel;
                    data_valid <= 1'b1;
                end
                default: begin
                    state          <= ST_IDLE;
                    {sc, oe, busy} <= moore(ST_IDLE);
                end
            endcase

            // Shared channel-advance path; overrides the state load above.
            if (advance) begin
                cnt <= '0;
                if (!last_ch) begin
                    ch_sel         <= ch_sel + CH_W'(1);
                    state          <= ST_START;
                    {sc, oe, busy} <= moore(ST_START);
                end else begin
                    done <= 1'b1;
`ifdef ADC_SCAN_CONT_EN
                    // Held go keeps sweeping without passing through IDLE,
                    // so timeout_err accumulates across sweeps.
                    if (go) begin
                        ch_sel         <= '0;
                        state          <= ST_START;
                        {sc, oe, busy} <= moore(ST_START);
                    end else begin
                        state          <= ST_IDLE;
                        {sc, oe, busy} <= moore(ST_IDLE);
                    end
`else
                    state          <= ST_IDLE;
                    {sc, oe, busy} <= moore(ST_IDLE);
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// Purpose: directed self-checking bench for adc_scan_ctrl with a behavioural ADC responder.
// Latency: n/a.
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_adc_scan_ctrl;

    localparam int N_CH = 4;

    logic       clk;
    logic       reset;
    logic       go;
    logic       eoc;
    logic [7:0] adc_data;
    logic       sc;
    logic       oe;
    logic [1:0] ch_sel;
    logic [7:0] data_out;
    logic [1:0] data_ch;
    logic       data_valid;
    logic       busy;
    logic       done;
    logic       timeout_err;

    adc_scan_ctrl #(
        .N_CH(4), .DATA_W(8), .SC_CYCLES(2), .TIMEOUT(16)
    ) dut (
        .clk(clk), .reset(reset), .go(go), .eoc(eoc), .adc_data(adc_data),
        .sc(sc), .oe(oe), .ch_sel(ch_sel), .data_out(data_out), .data_ch(data_ch),
        .data_valid(data_valid), .busy(busy), .done(done), .timeout_err(timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ADC model: eoc comes eoc_dly[ch] cycles after WAIT entry; -1 never.
    int eoc_dly [N_CH];
    int wcnt;
    initial begin
        eoc      = 1'b0;
        adc_data = '0;
        wcnt     = 0;
        forever begin
            @(posedge clk);
            #2;
            adc_data = 8'h10 + 8'(ch_sel);
            if (busy && !sc && oe) begin
                eoc = (eoc_dly[ch_sel] >= 0) && (wcnt == eoc_dly[ch_sel]);
                wcnt++;
            end else begin
                eoc  = 1'b0;
                wcnt = 0;
            end
        end
    end

    // Observation log, sampled on the falling edge.
    int         dv_n, done_n, done_dv_n, sc_hi_n, sc_pulse_n, idle_n, wrun;
    logic [7:0] dv_dat [64];
    logic [1:0] dv_ch  [64];
    int         wait_len [N_CH];
    logic       sc_prev;
    logic [1:0] wait_ch;
    initial begin
        dv_n = 0; done_n = 0; done_dv_n = 0; sc_hi_n = 0; sc_pulse_n = 0;
        idle_n = 0; wrun = 0; sc_prev = 1'b0; wait_ch = '0;
        forever begin
            @(negedge clk);
            if (data_valid) begin
                if (dv_n < 64) begin
                    dv_ch[dv_n]  = data_ch;
                    dv_dat[dv_n] = data_out;
                end
                dv_n++;
            end
            if (done) begin
                done_n++;
                if (data_valid) done_dv_n++;
            end
            if (sc) sc_hi_n++;
            if (sc && !sc_prev) sc_pulse_n++;
            sc_prev = sc;
            if (!busy) idle_n++;
            if (busy && !sc && oe) begin
                wrun++;
                wait_ch = ch_sel;
            end else if (wrun != 0) begin
                wait_len[wait_ch] = wrun;
                wrun = 0;
            end
        end
    end

    int dv0, sch0, scp0, dn0, ddv0, id0;

    task automatic snap();
        dv0 = dv_n; sch0 = sc_hi_n; scp0 = sc_pulse_n;
        dn0 = done_n; ddv0 = done_dv_n; id0 = idle_n;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int i;
        i = 0;
        while (!done && i < budget) begin
            tick();
            i++;
        end
        check(tag, done, 1'b1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    int found;

    initial begin
        reset = 1'b0;
        go    = 1'b0;
        for (int c = 0; c < N_CH; c++) eoc_dly[c] = 0;
        repeat (3) tick();

        // Reset state
        check("rst_sc", sc, 0);
        check("rst_oe", oe, 1);
        check("rst_busy", busy, 0);
        check("rst_ch_sel", ch_sel, 0);
        check("rst_dv", data_valid, 0);
        check("rst_done", done, 0);
        check("rst_terr", timeout_err, 0);
        check("rst_data", {data_ch, data_out}, 0);
        reset = 1'b1;
        tick(); tick();
        check("idle_busy", busy, 0);

        // Normal sweep, eoc one cycle after WAIT entry
        eoc_dly = '{1, 1, 1, 1};
        snap();
        go = 1'b1;
        tick();
        check("t2_sc_k1", sc, 1);
        check("t2_busy", busy, 1);
        tick();
        check("t2_sc_k2", sc, 1);
        tick();
        check("t2_wait1", {sc, oe}, 2'b01);
        tick();
        check("t2_wait2", {sc, oe}, 2'b01);
        tick();
        check("t2_read", {sc, oe}, 2'b00);
        check("t2_read_ch", ch_sel, 0);
        tick();
        check("t2_dv", data_valid, 1);
        check("t2_dv0", {data_ch, data_out}, {2'd0, 8'h10});
        check("t2_ch1_sc", {sc, ch_sel}, {1'b1, 2'd1});
        go = 1'b0;
        wait_done("t2_done", 200);
        check("t2_done_dv", data_valid, 1);
        check("t2_last", {data_ch, data_out}, {2'd3, 8'h13});
        check("t2_busy_done", busy, 0);
        tick();
        check("t2_dv_cnt", dv_n - dv0, 4);
        for (int i = 0; i < 4; i++) begin
            check("t2_seq_ch", dv_ch[dv0 + i], i);
            check("t2_seq_dat", dv_dat[dv0 + i], 8'h10 + i);
        end
        check("t2_sc_cycles", sc_hi_n - sch0, 8);
        check("t2_sc_pulses", sc_pulse_n - scp0, 4);
        check("t2_done_cnt", done_n - dn0, 1);
        check("t2_done_with_dv", done_dv_n - ddv0, 1);
        check("t2_terr", timeout_err, 0);

        // Channel 1 never converts -> timeout
        eoc_dly = '{0, -1, 0, 0};
        snap();
        go = 1'b1;
        tick();
        go = 1'b0;
        wait_done("t3_done", 300);
        tick();
        check("t3_dv_cnt", dv_n - dv0, 3);
        check("t3_s0", {dv_ch[dv0], dv_dat[dv0]}, {2'd0, 8'h10});
        check("t3_s1", {dv_ch[dv0 + 1], dv_dat[dv0 + 1]}, {2'd2, 8'h12});
        check("t3_s2", {dv_ch[dv0 + 2], dv_dat[dv0 + 2]}, {2'd3, 8'h13});
        check("t3_wait_len", wait_len[1], 16);
        check("t3_terr", timeout_err, 1);
        check("t3_done_with_dv", done_dv_n - ddv0, 1);
        check("t3_sc_pulses", sc_pulse_n - scp0, 4);
        repeat (5) tick();
        check("t3_terr_sticky", timeout_err, 1);

        // eoc on the very cycle the counter reaches 15
        eoc_dly = '{0, 15, 0, 0};
        snap();
        go = 1'b1;
        tick();
        check("t4_terr_clr", timeout_err, 0);
        go = 1'b0;
        wait_done("t4_done", 300);
        tick();
        check("t4_dv_cnt", dv_n - dv0, 4);
        check("t4_ch1", {dv_ch[dv0 + 1], dv_dat[dv0 + 1]}, {2'd1, 8'h11});
        check("t4_wait_len", wait_len[1], 16);
        check("t4_terr", timeout_err, 0);

        eoc_dly = '{0, 0, 0, 0};
`ifdef ADC_SCAN_CONT_EN
        // Continuous scan while go is held
        snap();
        go = 1'b1;
        for (int i = 0; i < 400 && (dv_n - dv0) < 8; i++) tick();
        check("t6_dv8", (dv_n - dv0) >= 8, 1);
        for (int i = 0; i < 8; i++) begin
            check("t6_seq_ch", dv_ch[dv0 + i], i % 4);
            check("t6_seq_dat", dv_dat[dv0 + i], 8'h10 + (i % 4));
        end
        check("t6_done_cnt", done_n - dn0, 2);
        check("t6_no_idle", idle_n - id0, 0);
        found = 0;
        for (int i = 0; i < 100; i++) begin
            if (ch_sel == 2'd2) begin
                found = 1;
                break;
            end
            tick();
        end
        check("t6_reach_ch2", found, 1);
        go = 1'b0;
        for (int i = 0; i < 100 && busy; i++) tick();
        check("t6_idle", busy, 0);
        tick();
        check("t6_dv_cnt", dv_n - dv0, 12);
        check("t6_last_ch", dv_ch[dv_n - 1], 3);
        check("t6_done_cnt3", done_n - dn0, 3);
`else
        // go re-pulsed mid-scan and held after done: one sweep only
        snap();
        go = 1'b1;
        for (int i = 0; i < 50 && !data_valid; i++) tick();
        check("t5_first_dv", data_valid, 1);
        go = 1'b0;
        tick();
        go = 1'b1;
        wait_done("t5_done", 200);
        id0 = idle_n;
        repeat (40) tick();
        check("t5_idle_hold", idle_n - id0, 40);
        check("t5_dv_cnt", dv_n - dv0, 4);
        check("t5_done_cnt", done_n - dn0, 1);
        check("t5_sc_pulses", sc_pulse_n - scp0, 4);
        check("t5_busy", busy, 0);
        go = 1'b0;
        tick();
`endif

        // Reset asserted mid-WAIT on channel 2
        eoc_dly = '{0, 0, -1, 0};
        go = 1'b1;
        tick();
        go = 1'b0;
        found = 0;
        for (int i = 0; i < 200; i++) begin
            if (ch_sel == 2'd2 && busy && !sc && oe) begin
                found = 1;
                break;
            end
            tick();
        end
        check("t1_reach_wait2", found, 1);
        repeat (3) tick();
        snap();
        reset = 1'b0;
        #1;
        check("t1_async_busy", busy, 0);
        tick();
        check("t1_sc_oe", {sc, oe}, 2'b01);
        check("t1_busy", busy, 0);
        check("t1_ch_sel", ch_sel, 0);
        check("t1_dv", data_valid, 0);
        repeat (5) tick();
        check("t1_no_done", done_n - dn0, 0);
        reset = 1'b1;
        repeat (3) tick();
        check("t1_stay_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
